mem_access_ctrl: RTL

- Sits between the EX/MEM pipeline latch and the data memory stage.
- Turns a single-cycle pipeline request (load/store) into a handshaked memory access. Holds memory-side signals stable until the memory reports done.
- Stalls the pipeline while an access is outstanding and flags unaligned or timed-out accesses.
- On halt, issues exactly one createdump pulse after all prior accesses have completed.

---
 rtl/mem_ctrl_pkg.sv | 23 ++
 rtl/mem_timeout_cnt.sv | 36 +++
 rtl/mem_access_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_ctrl_pkg
// Brief    : Shared state encoding and sizing constants for the memory
//            access controller.
// Revision : 1.0 - initial release
// ============================================================================
package mem_ctrl_pkg;

  localparam int WORD_W      = 16;
  localparam int DEF_TIMEOUT = 64;
  localparam int DEF_CNT_W   = 7;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_BUSY   = 3'd1,
    ST_RESP   = 3'd2,
    ST_DUMP   = 3'd3,
    ST_HALTED = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_timeout_cnt.sv
`default_nettype none
// ============================================================================
// Module   : mem_timeout_cnt
// Brief    : Counts BUSY cycles; tc flags the last cycle allowed before an
//            access is declared timed out.
// Revision : 1.0 - initial release
// ============================================================================
module mem_timeout_cnt #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam logic [CNT_W-1:0] C_TC_VAL = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (enable) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tc = (r_cnt == C_TC_VAL);

endmodule
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_ctrl
// Brief    : Converts single-cycle load/store requests into a held memory
//            handshake with stall, error response and a one-shot halt dump.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_wr,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic              halt_in,
  output logic              mem_enable,
  output logic              mem_wr,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_data_in,
  output logic              mem_createdump,
  input  logic [WORD_W-1:0] mem_data_out,
  input  logic              mem_done,
  output logic              stall_pipe,
  output logic              rsp_valid,
  output logic [WORD_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              halted
);

  state_t            r_state;
  state_t            w_next_state;
  logic              r_wr;
  logic [WORD_W-1:0] r_addr;
  logic [WORD_W-1:0] r_wdata;
  logic [WORD_W-1:0] r_data;
  logic              r_err;
  logic              w_tc;
  logic              w_busy;
  logic              w_accept;
  logic              w_aligned;

  assign w_busy    = (r_state == ST_BUSY);
  assign w_accept  = (r_state == ST_IDLE) && req_valid;
  assign w_aligned = ~req_addr[0];

  mem_timeout_cnt #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_timeout_cnt (
    .clk    (clk),
    .rst    (rst),
    .clear  (~w_busy),
    .enable (w_busy),
    .tc     (w_tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state   = r_state;
    mem_enable     = 1'b0;
    mem_wr         = 1'b0;
    mem_addr       = '0;
    mem_data_in    = '0;
    mem_createdump = 1'b0;
    stall_pipe     = 1'b0;
    rsp_valid      = 1'b0;
    rsp_data       = '0;
    rsp_err        = 1'b0;
    halted         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // rst gating keeps stall low while reset holds even if req_valid is high
        stall_pipe = req_valid & rst;
        if (req_valid) begin
          w_next_state = w_aligned ? ST_BUSY : ST_RESP;
        end else if (halt_in) begin
          w_next_state = ST_DUMP;
        end
      end
      ST_BUSY: begin
        mem_enable  = 1'b1;
        mem_wr      = r_wr;
        mem_addr    = r_addr;
        mem_data_in = r_wdata;
        stall_pipe  = 1'b1;
        if (mem_done || w_tc) begin
          w_next_state = ST_RESP;
        end
      end
      ST_RESP: begin
        rsp_valid    = 1'b1;
        rsp_data     = r_data;
        rsp_err      = r_err;
        w_next_state = ST_IDLE;
      end
      ST_DUMP: begin
        mem_createdump = 1'b1;
        w_next_state   = ST_HALTED;
      end
      ST_HALTED: begin
        halted = 1'b1;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_data  <= '0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      if (w_aligned) begin
        r_wr    <= req_wr;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end else begin
        r_data <= '0;
        r_err  <= 1'b1;
      end
    end else if (w_busy) begin
      // done takes priority over a coincident timeout
      if (mem_done) begin
        r_data <= r_wr ? '0 : mem_data_out;
        r_err  <= 1'b0;
      end else if (w_tc) begin
        r_data <= '0;
        r_err  <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
